refresh_arbiter: RTL and testbench
==================================

Name: refresh_arbiter

Overview:
- Sits between the command FIFO master side and `scheduler` in the `c0_ddr4_clk` domain.
- Shares the scheduler's 128-bit command input between the host command stream and internally generated DDR4 maintenance packets. A maintenance packet is PREA followed by one or more REF words.
- Tracks the tREFI interval and postpones refreshes while host packets are in flight, up to a fixed limit.
- Switches source only at packet boundaries, so host packets are never interleaved.

Parameters:
- CMD_WIDTH, 128, command word width.
- MAX_POSTPONE, 8, pending-refresh count that forces maintenance. This is the DDR4 postpone limit.
- TIMER_WIDTH, 16, width of the refresh interval timer and of refi_cycles.
- CNT_WIDTH, 16, width of the issued-refresh counter.

Ports:
- clk  in  1  scheduler clock (`c0_ddr4_clk`).
- rst  in  1  synchronous, active-high reset.
- enable  in  1  refresh generation enable (from control_r).
- refi_cycles  in  TIMER_WIDTH  tREFI in clk cycles; 0 disables the timer.
- S_AXIS_CMD_TDATA  in  CMD_WIDTH  host command word.
- S_AXIS_CMD_TVALID  in  1  host valid.
- S_AXIS_CMD_TREADY  out  1  host ready.
- S_AXIS_CMD_TLAST  in  1  host end of packet.
- M_AXIS_CMD_TDATA  out  CMD_WIDTH  command word to scheduler.
- M_AXIS_CMD_TVALID  out  1  valid to scheduler.
- M_AXIS_CMD_TREADY  in  1  scheduler ready.
- M_AXIS_CMD_TLAST  out  1  end of packet to scheduler.
- pending_ref  out  4  postponed refreshes outstanding (0..MAX_POSTPONE).
- ref_issued  out  CNT_WIDTH  REF words accepted by the scheduler; wraps.
- overflow  out  1  sticky; the timer fired while pending_ref==MAX_POSTPONE.
- busy  out  1  high in the MAINT_PREA and MAINT_REF states.

Behaviour:
- Reset (and 1 cycle after rst asserted):
  - state = IDLE, timer = 0, pending_ref = 0, ref_issued = 0, overflow = 0, busy = 0.
  - M_AXIS_CMD_TVALID = 0, S_AXIS_CMD_TREADY = 0, M_AXIS_CMD_TDATA = 0, M_AXIS_CMD_TLAST = 0.
  - Reset mid-packet abandons the packet; no further words are emitted.
- Timer:
  - Counts only when enable=1 and refi_cycles!=0; otherwise it is held at 0.
  - Tick = (timer == refi_cycles-1). On a tick, timer returns to 0.
  - Tick with pending_ref<MAX_POSTPONE: pending_ref += 1.
  - Tick with pending_ref==MAX_POSTPONE: pending_ref holds and overflow is set (sticky until rst).
  - Tick and REF handshake in the same cycle: pending_ref is unchanged (net zero).
  - Deasserting enable does not clear pending_ref; pending refreshes still drain.
- States:
  - IDLE (packet boundary):
    - pending_ref>=MAX_POSTPONE, or (pending_ref>=1 and S_AXIS_CMD_TVALID=0): go to MAINT_PREA.
    - Else if S_AXIS_CMD_TVALID=1: pass through this cycle. The M_AXIS_CMD handshake on a non-last word moves to HOST_PKT; a last word stays in IDLE.
    - Selection priority in IDLE is the forced condition first, then the opportunistic one, then host.
  - HOST_PKT:
    - Combinational pass-through: M_AXIS_CMD_TDATA/TVALID/TLAST = S_AXIS_CMD_* and S_AXIS_CMD_TREADY = M_AXIS_CMD_TREADY. Zero latency.
    - Handshake with TLAST=1 returns to IDLE.
    - Refresh is never inserted mid-packet, regardless of pending_ref.
  - MAINT_PREA:
    - S_AXIS_CMD_TREADY = 0.
    - Drives PREA_WORD with M_AXIS_CMD_TVALID=1 and TLAST=0.
    - On handshake, go to MAINT_REF.
  - MAINT_REF:
    - Drives REF_WORD.
    - TLAST = (pending_ref==1 and no tick this cycle).
    - Each handshake: pending_ref -= 1 and ref_issued += 1.
    - The handshake with TLAST=1 returns to IDLE.
    - A tick during MAINT_REF extends the burst by one REF.
- AXIS rules:
  - Once M_AXIS_CMD_TVALID is high in a MAINT state, TDATA and TVALID hold until TREADY.
  - TLAST may only rise within a held word, never fall. A tick can turn TLAST 0→1 is not possible, since a tick only extends the burst.
  - Host words are never dropped or duplicated.

Decomposition:
- Package `sddt_cmd_pkg`:
  - Opcode field position and width.
  - PREA_WORD and REF_WORD constants. PREA_WORD has the PALL bit set.
  - State enum.
- Sub-module `refi_timer`: the timer, tick generation and pending counter with saturation and overflow.
- The FSM and muxing stay at top level.

Test Plan:
- Host-only pass-through: enable=0; 3-word host packet 0x11,0x22,0x33 with TLAST on the 3rd → the same words appear in the same cycles on M_AXIS_CMD, TLAST on 0x33, pending_ref=0.
- Idle refresh: enable=1, refi_cycles=100, host idle → pending_ref=1 at cycle 100, then PREA_WORD, then REF_WORD with TLAST; ref_issued=1, pending_ref=0.
- Packet integrity: tick while a 6-word host packet is mid-transfer and host keeps TVALID=1 → all 6 words are contiguous; maintenance starts only after TLAST when host TVALID drops.
- Forced postpone: refi_cycles=10, host streaming back-to-back 1-word packets → at pending_ref=8, PREA plus 8 REFs are emitted with TLAST on the 8th REF; ref_issued=8; overflow stays 0.
- Backpressure plus overflow: M_AXIS_CMD_TREADY=0 held during MAINT_PREA for 100 cycles with refi_cycles=10 → PREA_WORD is stable throughout, pending_ref saturates at 8, overflow=1.
- Reset mid-maintenance: assert rst during the 3rd REF of a burst → the next cycle shows TVALID=0, busy=0, pending_ref=0, ref_issued=0.

Source files
------------

// File: rtl/sddt_cmd_pkg.sv
// Shared command-word layout, maintenance packet constants and arbiter state
// encoding for the scheduler command path.
package sddt_cmd_pkg;

  localparam int CMD_W      = 128;
  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_W   = 4;
  // DDR4 A10 on a precharge selects all banks (PALL)
  localparam int PALL_BIT   = 10;

  localparam logic [OPCODE_W-1:0] OP_PRE = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_REF = 4'h1;

  localparam logic [CMD_W-1:0] PREA_WORD =
    (CMD_W'(OP_PRE) << OPCODE_LSB) | (CMD_W'(1) << PALL_BIT);
  localparam logic [CMD_W-1:0] REF_WORD =
    (CMD_W'(OP_REF) << OPCODE_LSB);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_HOST_PKT   = 2'd1,
    ST_MAINT_PREA = 2'd2,
    ST_MAINT_REF  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/refresh_arbiter_if.sv
// Command-stream link between the command FIFO, the refresh arbiter and the scheduler.
// Valid/ready: a word transfers on a rising clk edge where TVALID and TREADY are both
// high; while TVALID is high and TREADY low the source holds TDATA/TLAST stable.
interface refresh_arbiter_if #(
  parameter int W = 128
);
  logic [W-1:0] TDATA;
  logic         TVALID;
  logic         TREADY;
  logic         TLAST;

  modport master (output TDATA, output TVALID, output TLAST, input TREADY);
  modport slave  (input TDATA, input TVALID, input TLAST, output TREADY);
endinterface

// File: rtl/refi_timer.sv
// tREFI interval timer: generates refresh ticks and keeps the count of postponed
// refreshes, saturating at MAX_POSTPONE with a sticky overflow flag.
module refi_timer import sddt_cmd_pkg::*; #(
  parameter int TIMER_WIDTH  = 16,
  parameter int MAX_POSTPONE = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [TIMER_WIDTH-1:0] refi_cycles,
  input  logic                   ref_done,
  output logic                   tick,
  output logic [3:0]             pending_ref,
  output logic                   overflow
);

  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic [3:0]             pending_q, pending_d;
  logic                   overflow_q, overflow_d;
  logic                   run;
  logic                   at_max;

  always_comb begin
    run        = enable && (refi_cycles != '0);
    tick       = run && (timer_q == (refi_cycles - TIMER_WIDTH'(1)));
    at_max     = (pending_q >= 4'(MAX_POSTPONE));
    timer_d    = '0;
    if (run && !tick) timer_d = timer_q + TIMER_WIDTH'(1);
    pending_d  = pending_q;
    overflow_d = overflow_q | (tick & at_max);
    // A tick and a REF handshake in the same cycle cancel out
    if (tick && !ref_done) begin
      if (!at_max) pending_d = pending_q + 4'd1;
    end else if (!tick && ref_done && (pending_q != 4'd0)) begin
      pending_d = pending_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q    <= '0;
      pending_q  <= 4'd0;
      overflow_q <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign pending_ref = pending_q;
  assign overflow    = overflow_q;

endmodule

// File: rtl/refresh_arbiter.sv
// Shares the scheduler command input between host packets and PREA+REF maintenance
// packets, switching source only at packet boundaries.
module refresh_arbiter import sddt_cmd_pkg::*; #(
  parameter int CMD_WIDTH    = 128,
  parameter int MAX_POSTPONE = 8,
  parameter int TIMER_WIDTH  = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [TIMER_WIDTH-1:0] refi_cycles,
  refresh_arbiter_if.slave       S_AXIS_CMD,
  refresh_arbiter_if.master      M_AXIS_CMD,
  output logic [3:0]             pending_ref,
  output logic [CNT_WIDTH-1:0]   ref_issued,
  output logic                   overflow,
  output logic                   busy
);

  arb_state_e             state_q, state_d;
  logic                   last_q, last_d;
  logic                   busy_q, busy_d;
  logic [CNT_WIDTH-1:0]   ref_cnt_q, ref_cnt_d;

  logic                   tick;
  logic                   ref_done;
  logic                   host_sel;
  logic                   maint_force;
  logic                   maint_opp;
  logic [CMD_WIDTH-1:0]   m_tdata;
  logic                   m_tvalid;
  logic                   m_tlast;
  logic                   s_tready;

  refi_timer #(
    .TIMER_WIDTH  (TIMER_WIDTH),
    .MAX_POSTPONE (MAX_POSTPONE)
  ) u_refi_timer (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .refi_cycles (refi_cycles),
    .ref_done    (ref_done),
    .tick        (tick),
    .pending_ref (pending_ref),
    .overflow    (overflow)
  );

  always_comb begin
    maint_force = (pending_ref >= 4'(MAX_POSTPONE));
    maint_opp   = (pending_ref != 4'd0) && !S_AXIS_CMD.TVALID;
    state_d     = state_q;
    last_d      = last_q;
    host_sel    = 1'b0;
    ref_done    = 1'b0;
    m_tdata     = '0;
    m_tvalid    = 1'b0;
    m_tlast     = 1'b0;
    s_tready    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (maint_force || maint_opp) begin
          state_d = ST_MAINT_PREA;
        end else if (S_AXIS_CMD.TVALID) begin
          host_sel = 1'b1;
          if (M_AXIS_CMD.TREADY && !S_AXIS_CMD.TLAST) state_d = ST_HOST_PKT;
        end
      end
      ST_HOST_PKT: begin
        host_sel = 1'b1;
        if (S_AXIS_CMD.TVALID && M_AXIS_CMD.TREADY && S_AXIS_CMD.TLAST) state_d = ST_IDLE;
      end
      ST_MAINT_PREA: begin
        m_tdata  = CMD_WIDTH'(PREA_WORD);
        m_tvalid = 1'b1;
        if (M_AXIS_CMD.TREADY) state_d = ST_MAINT_REF;
      end
      ST_MAINT_REF: begin
        m_tdata  = CMD_WIDTH'(REF_WORD);
        m_tvalid = 1'b1;
        // last_q keeps TLAST from falling if a tick lands while the last REF is stalled
        m_tlast  = last_q || ((pending_ref == 4'd1) && !tick);
        if (M_AXIS_CMD.TREADY) begin
          ref_done = 1'b1;
          last_d   = 1'b0;
          if (m_tlast) state_d = ST_IDLE;
        end else begin
          last_d = m_tlast;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (host_sel) begin
      m_tdata  = S_AXIS_CMD.TDATA;
      m_tvalid = S_AXIS_CMD.TVALID;
      m_tlast  = S_AXIS_CMD.TLAST;
      s_tready = M_AXIS_CMD.TREADY;
    end
    busy_d    = (state_d == ST_MAINT_PREA) || (state_d == ST_MAINT_REF);
    ref_cnt_d = ref_done ? (ref_cnt_q + CNT_WIDTH'(1)) : ref_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      ref_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      ref_cnt_q <= ref_cnt_d;
    end
  end

  assign M_AXIS_CMD.TDATA  = m_tdata;
  assign M_AXIS_CMD.TVALID = m_tvalid;
  assign M_AXIS_CMD.TLAST  = m_tlast;
  assign S_AXIS_CMD.TREADY = s_tready;
  assign ref_issued        = ref_cnt_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_refresh_arbiter.sv
// Directed bench for refresh_arbiter: scoreboarded output stream plus point checks
// of pending/overflow/ref_issued around refresh, postpone and reset scenarios.
module tb_refresh_arbiter;

  localparam int W = 128;
  localparam logic [W-1:0] PREA_W = 128'h402;
  localparam logic [W-1:0] REF_W  = 128'h1;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [15:0]   refi_cycles;
  logic [3:0]    pending_ref;
  logic [15:0]   ref_issued;
  logic          overflow;
  logic          busy;

  refresh_arbiter_if #(.W(W)) s_axis();
  refresh_arbiter_if #(.W(W)) m_axis();

  refresh_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .refi_cycles (refi_cycles),
    .S_AXIS_CMD  (s_axis),
    .M_AXIS_CMD  (m_axis),
    .pending_ref (pending_ref),
    .ref_issued  (ref_issued),
    .overflow    (overflow),
    .busy        (busy)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // scoreboard: {tlast, tdata}
  logic [W:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always begin
    logic [W:0] exp_w;
    @(negedge clk);
    #2;
    if (m_axis.TVALID === 1'b1 && m_axis.TREADY === 1'b1) begin
      check("sb_word_expected", (exp_q.size() != 0), 1'b1);
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        check("sb_word", {m_axis.TLAST, m_axis.TDATA}, exp_w);
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    s_axis.TVALID = 1'b0;
    s_axis.TLAST = 1'b0;
    s_axis.TDATA = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic push_maint(input int n_ref);
    exp_q.push_back({1'b0, PREA_W});
    for (int i = 0; i < n_ref; i++) exp_q.push_back({(i == n_ref - 1), REF_W});
  endtask

  task automatic send_word(input logic [W-1:0] data, input logic last);
    int  waits;
    logic hit;
    waits = 0;
    hit = 1'b0;
    s_axis.TDATA = data;
    s_axis.TLAST = last;
    s_axis.TVALID = 1'b1;
    for (int i = 0; i < 64 && !hit; i++) begin
      @(negedge clk);
      if (s_axis.TREADY === 1'b1) begin
        hit = 1'b1;
        exp_q.push_back({last, data});
        check("host_same_cycle", {m_axis.TVALID, m_axis.TLAST, m_axis.TDATA}, {1'b1, last, data});
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    check("host_accepted", hit, 1'b1);
    check("host_no_stall", waits, 0);
  endtask

  task automatic wait_busy(input string tag, input logic level);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (busy === level) hit = 1'b1;
    end
    check(tag, hit, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_mhs(input string tag);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      if (m_axis.TVALID === 1'b1 && m_axis.TREADY === 1'b1) hit = 1'b1;
      @(posedge clk);
      #1;
    end
    check(tag, hit, 1'b1);
  endtask

  // directed sequence
  initial begin
    logic [W-1:0] word;
    int n_host;
    int n_after;
    logic seen_maint;

    rst = 1'b1;
    enable = 1'b0;
    refi_cycles = 16'd0;
    s_axis.TVALID = 1'b0;
    s_axis.TLAST = 1'b0;
    s_axis.TDATA = '0;
    m_axis.TREADY = 1'b1;

    // reset state
    @(posedge clk);
    @(negedge clk);
    check("rst_m_tvalid", m_axis.TVALID, 1'b0);
    check("rst_s_tready", s_axis.TREADY, 1'b0);
    check("rst_m_tdata", m_axis.TDATA, '0);
    check("rst_m_tlast", m_axis.TLAST, 1'b0);
    check("rst_pending", pending_ref, 4'd0);
    check("rst_ref_issued", ref_issued, 16'd0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // host-only pass-through
    enable = 1'b0;
    refi_cycles = 16'd10;
    send_word(128'h11, 1'b0);
    send_word(128'h22, 1'b0);
    send_word(128'h33, 1'b1);
    s_axis.TVALID = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("host_only_pending", pending_ref, 4'd0);
    check("host_only_busy", busy, 1'b0);

    // idle refresh after one tREFI
    do_reset();
    push_maint(1);
    enable = 1'b1;
    refi_cycles = 16'd100;
    repeat (99) @(posedge clk);
    @(negedge clk);
    check("idle_pending_before_tick", pending_ref, 4'd0);
    @(negedge clk);
    check("idle_pending_at_tick", pending_ref, 4'd1);
    check("idle_busy_at_tick", busy, 1'b0);
    @(negedge clk);
    check("idle_busy_prea", busy, 1'b1);
    @(posedge clk);
    #1;
    wait_busy("idle_maint_done", 1'b0);
    enable = 1'b0;
    check("idle_ref_issued", ref_issued, 16'd1);
    check("idle_pending_drained", pending_ref, 4'd0);

    // packet integrity: tick lands mid-packet
    do_reset();
    enable = 1'b1;
    refi_cycles = 16'd4;
    for (int i = 0; i < 6; i++) begin
      send_word(W'(128'hA0 + i), (i == 5));
      if (i == 3) begin
        check("pkt_pending_mid", pending_ref, 4'd1);
        check("pkt_busy_mid", busy, 1'b0);
      end
      if (i == 4) enable = 1'b0;
    end
    s_axis.TVALID = 1'b0;
    push_maint(1);
    wait_busy("pkt_maint_start", 1'b1);
    wait_busy("pkt_maint_done", 1'b0);
    check("pkt_ref_issued", ref_issued, 16'd1);
    check("pkt_pending_drained", pending_ref, 4'd0);

    // forced maintenance under back-to-back 1-word host packets
    do_reset();
    enable = 1'b1;
    refi_cycles = 16'd10;
    word = 128'h1000;
    s_axis.TDATA = word;
    s_axis.TLAST = 1'b1;
    s_axis.TVALID = 1'b1;
    n_host = 0;
    n_after = 0;
    seen_maint = 1'b0;
    for (int cyc = 0; cyc < 400 && n_after < 3; cyc++) begin
      @(negedge clk);
      if (s_axis.TREADY === 1'b1) begin
        exp_q.push_back({1'b1, word});
        word = word + W'(1);
        if (seen_maint) n_after++;
        else n_host++;
      end else if (!seen_maint && busy === 1'b0) begin
        seen_maint = 1'b1;
        check("force_pending_at_limit", pending_ref, 4'd8);
        check("force_host_words_before", n_host, 80);
        push_maint(8);
      end
      @(posedge clk);
      #1;
      if (seen_maint) enable = 1'b0;
      s_axis.TDATA = word;
    end
    s_axis.TVALID = 1'b0;
    check("force_maint_seen", seen_maint, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("force_ref_issued", ref_issued, 16'd8);
    check("force_pending_drained", pending_ref, 4'd0);
    check("force_no_overflow", overflow, 1'b0);

    // backpressure during PREA with saturation and overflow
    do_reset();
    m_axis.TREADY = 1'b0;
    enable = 1'b1;
    refi_cycles = 16'd10;
    wait_busy("bp_enter_prea", 1'b1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("bp_prea_hold", {m_axis.TVALID, m_axis.TLAST, m_axis.TDATA}, {1'b1, 1'b0, PREA_W});
    end
    check("bp_pending_saturated", pending_ref, 4'd8);
    check("bp_overflow_set", overflow, 1'b1);
    @(posedge clk);
    #1;
    enable = 1'b0;
    push_maint(8);
    m_axis.TREADY = 1'b1;
    wait_busy("bp_maint_done", 1'b0);
    check("bp_ref_issued", ref_issued, 16'd8);
    check("bp_pending_drained", pending_ref, 4'd0);
    check("bp_overflow_sticky", overflow, 1'b1);

    // reset in the middle of a REF burst
    do_reset();
    m_axis.TREADY = 1'b0;
    enable = 1'b1;
    refi_cycles = 16'd10;
    repeat (45) @(posedge clk);
    #1;
    enable = 1'b0;
    check("rstmid_pending", pending_ref, 4'd4);
    check("rstmid_busy", busy, 1'b1);
    exp_q.push_back({1'b0, PREA_W});
    exp_q.push_back({1'b0, REF_W});
    exp_q.push_back({1'b0, REF_W});
    m_axis.TREADY = 1'b1;
    wait_mhs("rstmid_prea_hs");
    wait_mhs("rstmid_ref1_hs");
    wait_mhs("rstmid_ref2_hs");
    check("rstmid_ref_issued_pre", ref_issued, 16'd2);
    check("rstmid_third_ref_shown", {m_axis.TVALID, m_axis.TDATA}, {1'b1, REF_W});
    rst = 1'b1;
    m_axis.TREADY = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rstmid_tvalid", m_axis.TVALID, 1'b0);
    check("rstmid_busy_clr", busy, 1'b0);
    check("rstmid_pending_clr", pending_ref, 4'd0);
    check("rstmid_ref_issued_clr", ref_issued, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_axis.TREADY = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rstmid_quiet_tvalid", m_axis.TVALID, 1'b0);
    check("rstmid_quiet_ref_issued", ref_issued, 16'd0);

    // final report
    check("sb_all_consumed", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
